// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between the core MEM stage and the data memory.
interface data_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        init_busy;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, init_busy
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, init_busy
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// RV32I data memory: byte-lane stores, extended loads, error flagging,
// fixed-latency in-order responses and an optional post-reset zero sweep.
module data_mem_ctrl #(
  parameter int unsigned DEPTH_WORDS   = 1024,
  parameter int unsigned RD_LATENCY    = 1,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input logic           clk,
  input logic           rst,
  data_mem_ctrl_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [0:0] ST_RESET = INIT_ON_RESET ? ST_INIT : ST_RUN;

  logic [0:0]    state, state_next;
  logic [AW-1:0] cnt, cnt_next;
  logic          sweep_we;
  logic          ready, busy;

  logic [31:0]   mem [DEPTH_WORDS];

  // State register plus registered ready/busy decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RESET;
      cnt   <= '0;
      ready <= (ST_RESET == ST_RUN);
      busy  <= (ST_RESET == ST_INIT);
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      ready <= (state_next == ST_RUN);
      busy  <= (state_next == ST_INIT);
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    sweep_we   = 1'b0;
    case (state)
      ST_INIT: begin
        sweep_we = 1'b1;
        cnt_next = cnt + AW'(1);
        if (cnt == AW'(DEPTH_WORDS - 1)) state_next = ST_RUN;
      end
      ST_RUN: ;
      default: state_next = ST_RESET;
    endcase
  end

  logic          accept;
  logic [1:0]    lane;
  logic [AW-1:0] idx;
  logic [31:0]   word_addr;
  logic          err;
  logic [3:0]    be;
  logic [31:0]   wrep, mask, rd_word, wr_word, sh, ld_data;

  assign accept    = bus.req_valid && ready;
  assign lane      = bus.req_addr[1:0];
  assign idx       = bus.req_addr[2 +: AW];
  assign word_addr = {2'b00, bus.req_addr[31:2]};

  always_comb begin
    case (bus.req_size)
      2'b00:   err = 1'b0;
      2'b01:   err = lane[0];
      2'b10:   err = (lane != 2'b00);
      default: err = 1'b1;
    endcase
    if (word_addr >= DEPTH_WORDS) err = 1'b1;
  end

  // Store lane enables and replicated data; only meaningful when err is clear
  always_comb begin
    be   = 4'b0000;
    wrep = '0;
    case (bus.req_size)
      2'b00: begin
        be   = 4'b0001 << lane;
        wrep = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        be   = lane[1] ? 4'b1100 : 4'b0011;
        wrep = {2{bus.req_wdata[15:0]}};
      end
      2'b10: begin
        be   = 4'b1111;
        wrep = bus.req_wdata;
      end
      default: ;
    endcase
  end

  assign mask    = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign rd_word = mem[idx];
  assign wr_word = (rd_word & ~mask) | (wrep & mask);
  assign sh      = rd_word >> {lane, 3'b000};

  always_comb begin
    case (bus.req_size)
      2'b00:   ld_data = bus.req_unsigned ? {24'h0, sh[7:0]}   : {{24{sh[7]}}, sh[7:0]};
      2'b01:   ld_data = bus.req_unsigned ? {16'h0, sh[15:0]}  : {{16{sh[15]}}, sh[15:0]};
      2'b10:   ld_data = rd_word;
      default: ld_data = '0;
    endcase
  end

  // Array is never reset; the sweep and committed stores are the only writers
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[cnt] <= '0;
    end else if (accept && bus.req_we && !err) begin
      mem[idx] <= wr_word;
    end
  end

  logic [RD_LATENCY-1:0]       pv, pe;
  logic [RD_LATENCY-1:0][31:0] pd;

  // Response pipeline: stage 0 captures the result at the acceptance edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
      pe <= '0;
      pd <= '0;
    end else begin
      pv[0] <= accept;
      pe[0] <= accept && err;
      pd[0] <= (accept && !bus.req_we && !err) ? ld_data : 32'h0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  assign bus.req_ready  = ready;
  assign bus.init_busy  = busy;
  assign bus.resp_valid = pv[RD_LATENCY-1];
  assign bus.resp_err   = pe[RD_LATENCY-1];
  assign bus.resp_rdata = pd[RD_LATENCY-1];
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: two instances (latency 1 and 3) share one stimulus
// stream and are checked against a byte-addressed reference memory.
module tb_data_mem_ctrl;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned NB    = DEPTH * 4;
  localparam int unsigned BW    = $clog2(NB);

  logic clk;
  logic rst;

  data_mem_ctrl_if i1 ();
  data_mem_ctrl_if i3 ();

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .RD_LATENCY(1), .INIT_ON_RESET(1'b1))
    dut1 (.clk(clk), .rst(rst), .bus(i1.slave));
  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .RD_LATENCY(3), .INIT_ON_RESET(1'b1))
    dut3 (.clk(clk), .rst(rst), .bus(i3.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t       q1[$];
  exp_t       q3[$];
  logic [7:0] mb [NB];
  int         cyc;
  int         since;
  bit         m_ready;
  int         n_cmp;
  int         n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Little-endian byte memory model of the spec's access rules
  function automatic void model_req(input bit we, input logic [1:0] sz, input bit uns,
                                    input logic [31:0] a, input logic [31:0] wd,
                                    output logic [31:0] rd, output logic e);
    int          nb;
    logic [31:0] val;
    logic [BW-1:0] bi;
    e  = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
         || ({2'b00, a[31:2]} >= DEPTH);
    rd = '0;
    if (!e) begin
      nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      val = '0;
      for (int i = 0; i < nb; i++) begin
        bi = a[BW-1:0] + BW'(i);
        if (we) mb[bi] = wd[8*i +: 8];
        else    val[8*i +: 8] = mb[bi];
      end
      if (!we) begin
        if (!uns && val[8*nb-1])
          for (int i = nb; i < 4; i++) val[8*i +: 8] = 8'hFF;
        rd = val;
      end
    end
  endfunction

  task automatic drive(input bit v, input bit we, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd);
    i1.req_valid = v;  i1.req_we = we; i1.req_size = sz; i1.req_unsigned = uns;
    i1.req_addr  = a;  i1.req_wdata = wd;
    i3.req_valid = v;  i3.req_we = we; i3.req_size = sz; i3.req_unsigned = uns;
    i3.req_addr  = a;  i3.req_wdata = wd;
  endtask

  task automatic chk_resp(input string tag, input logic v, input logic [31:0] d,
                          input logic e, input int k);
    exp_t x;
    bit   ev;
    ev = 1'b0;
    x  = '{due: 0, rdata: '0, err: 1'b0};
    if (k == 1 && q1.size() > 0 && q1[0].due == cyc) begin x = q1.pop_front(); ev = 1'b1; end
    if (k == 3 && q3.size() > 0 && q3[0].due == cyc) begin x = q3.pop_front(); ev = 1'b1; end
    chk({tag, ".resp_valid"}, 32'(v), 32'(ev));
    if (ev) begin
      chk({tag, ".resp_rdata"}, d, x.rdata);
      chk({tag, ".resp_err"}, 32'(e), 32'(x.err));
    end
  endtask

  task automatic post_check();
    chk_resp("lat1", i1.resp_valid, i1.resp_rdata, i1.resp_err, 1);
    chk_resp("lat3", i3.resp_valid, i3.resp_rdata, i3.resp_err, 3);
    chk("lat1.req_ready", 32'(i1.req_ready), 32'(m_ready));
    chk("lat1.init_busy", 32'(i1.init_busy), 32'(!m_ready));
    chk("lat3.req_ready", 32'(i3.req_ready), 32'(m_ready));
  endtask

  task automatic step(input bit v, input bit we, input logic [1:0] sz, input bit uns,
                      input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] rd;
    logic        e;
    exp_t        x;
    drive(v, we, sz, uns, a, wd);
    @(posedge clk);
    cyc++;
    if (!rst && v && m_ready) begin
      model_req(we, sz, uns, a, wd, rd, e);
      x.rdata = rd;
      x.err   = e;
      x.due   = cyc;
      q1.push_back(x);
      x.due   = cyc + 2;
      q3.push_back(x);
    end
    if (!rst) begin
      since++;
      m_ready = (since >= int'(DEPTH));
    end
    #1;
    post_check();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic ld(input logic [1:0] sz, input bit uns, input logic [31:0] a);
    step(1'b1, 1'b0, sz, uns, a, 32'h0);
  endtask

  task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    step(1'b1, 1'b1, sz, 1'b0, a, wd);
  endtask

  // Async reset assertion: in-flight responses vanish, sweep will re-zero the array
  task automatic do_reset();
    rst = 1'b1;
    q1.delete();
    q3.delete();
    since   = 0;
    m_ready = 1'b0;
    foreach (mb[i]) mb[i] = 8'h00;
    #1;
    chk("rst.resp_valid1", 32'(i1.resp_valid), 32'h0);
    chk("rst.resp_valid3", 32'(i3.resp_valid), 32'h0);
    chk("rst.resp_rdata3", i3.resp_rdata, 32'h0);
    chk("rst.resp_err3", 32'(i3.resp_err), 32'h0);
    chk("rst.req_ready1", 32'(i1.req_ready), 32'h0);
    chk("rst.init_busy3", 32'(i3.init_busy), 32'h1);
    idle(3);
    rst = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    cyc    = 0;
    since  = 0;
    m_ready = 1'b0;
    rst    = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    #2;
    do_reset();
    ld(2'b10, 1'b0, 32'h0000_0004);
    idle(15);

    ld(2'b10, 1'b0, 32'h0000_003C);
    st(2'b10, 32'h10, 32'h8000_00F0);
    ld(2'b00, 1'b0, 32'h10);
    ld(2'b00, 1'b1, 32'h13);
    ld(2'b01, 1'b0, 32'h12);
    ld(2'b01, 1'b1, 32'h12);
    st(2'b10, 32'h20, 32'h1122_3344);
    st(2'b00, 32'h21, 32'h0000_00AB);
    ld(2'b10, 1'b0, 32'h20);
    st(2'b01, 32'h22, 32'h0000_BEEF);
    ld(2'b10, 1'b0, 32'h20);
    ld(2'b01, 1'b0, 32'h05);
    st(2'b10, 32'h04, 32'h5555_AAAA);
    st(2'b10, 32'h06, 32'hDEAD_BEEF);
    ld(2'b10, 1'b0, 32'h04);
    ld(2'b11, 1'b0, 32'h00);
    ld(2'b10, 1'b0, 32'h40);
    ld(2'b00, 1'b1, 32'hFFFF_FFF0);
    idle(3);

    st(2'b10, 32'h08, 32'hCAFE_F00D);
    ld(2'b10, 1'b0, 32'h08);
    ld(2'b10, 1'b0, 32'h10);
    ld(2'b01, 1'b0, 32'h22);
    ld(2'b00, 1'b0, 32'h20);
    ld(2'b10, 1'b0, 32'h3C);
    idle(4);

    ld(2'b10, 1'b0, 32'h08);
    ld(2'b10, 1'b0, 32'h10);
    do_reset();
    idle(16);
    ld(2'b10, 1'b0, 32'h08);
    ld(2'b10, 1'b0, 32'h10);
    idle(3);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 32'h4F));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1, a, $urandom);
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised RV32I data memory with a request/response handshake, replacing the bare byte-select memory. It accepts one load/store per cycle from the core's MEM stage, derives byte lanes from access size and address, sign- or zero-extends loads, and flags misaligned or out-of-range accesses. Responses come back through a configurable-latency pipeline. A post-reset sweep clears the array to zero.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; power of two, at least 4.
RD_LATENCY, 1, cycles from request acceptance to response; legal range 1..4.
INIT_ON_RESET, 1, 1 = zero-fill sweep after reset; 0 = skip the sweep.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request this cycle.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
req_unsigned  in  1  load zero-extend (LBU/LHU); ignored for stores and words.
req_addr  in  32  byte address.
req_wdata  in  32  store data, right-aligned.
resp_valid  out  1  response valid, one-cycle pulse per accepted request.
resp_rdata  out  32  extended load data; 0 for stores and errors.
resp_err  out  1  misaligned, reserved-size or out-of-range access.
init_busy  out  1  zero-fill sweep in progress.

Behaviour:
- Reset (async assert): state=INIT (or RUN if INIT_ON_RESET=0), sweep counter=0, all pipeline valids=0. resp_valid=0, resp_rdata=0, resp_err=0. req_ready=0 while in INIT. Array contents are not reset asynchronously.
- FSM INIT: each cycle writes 0 to word[counter], then increments the counter. After word DEPTH_WORDS-1 it moves to RUN. Sweep takes exactly DEPTH_WORDS cycles after rst deasserts. init_busy=1 only in INIT.
- FSM RUN: req_ready=1 every cycle; no response backpressure. A request is accepted when req_valid && req_ready.
- Word index = req_addr[2+:log2(DEPTH_WORDS)]; lane = req_addr[1:0].
- Error when any of these holds:
  - size=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - req_addr[31:2] >= DEPTH_WORDS.
- An erroring request performs no write and returns resp_err=1, rdata=0.
- Store lanes:
  - byte: enable lane addr[1:0], data = wdata[7:0] replicated ×4;
  - half: lanes {addr[1],0} and {addr[1],1}, data = wdata[15:0] replicated ×2;
  - word: all lanes.
  - The write commits at the acceptance edge.
- Load: synchronous array read at the acceptance edge. The selected byte/half is shifted to bit 0 and sign-extended unless req_unsigned=1.
- Every accepted request yields exactly one response, exactly RD_LATENCY cycles after the acceptance edge. Responses are in order. Stores respond with rdata=0, err as computed.
- Read-after-write: a load accepted the cycle after a store to the same word returns the updated data. No same-cycle hazard exists (one request per cycle).
- Back-to-back requests every cycle produce back-to-back resp_valid pulses.
- Reset mid-operation: in-flight responses are dropped (no resp_valid). Array writes already committed remain. INIT re-runs.

Test Plan:
- Reset, DEPTH_WORDS=16 → init_busy=1 and req_ready=0 for 16 cycles after rst falls, then req_ready=1. Load word at 0x3C → rdata 0x00000000.
- Store word 0x8000_00F0 at 0x10; then LB 0x10 → 0xFFFF_FFF0; LBU 0x13 → 0x0000_0080; LH 0x12 → 0xFFFF_8000; LHU 0x12 → 0x0000_8000.
- Store byte 0xAB at 0x21 over word 0x1122_3344 → LW 0x20 = 0x1122_AB44. Store half 0xBEEF at 0x22 → LW 0x20 = 0xBEEF_AB44.
- Errors:
  - LH 0x05 → err=1, rdata=0.
  - SW 0x06 → err=1, and a following LW 0x04 shows the word unchanged.
  - size=11 → err=1.
  - LW 0x40 with DEPTH_WORDS=16 → err=1.
- RD_LATENCY=3: SW 0x8=0xCAFEF00D, then LW 0x8 on the next cycle, then 4 more loads back-to-back → resp_valid pulses on 6 consecutive cycles, the first 3 cycles after the SW. The LW 0x8 response = 0xCAFEF00D.
- Assert rst with 2 loads in flight → no resp_valid for them. INIT repeats. Data stored before reset reads back 0 after the sweep.
